rgb_set_lane_arbiter: RTL and testbench
=======================================

# rgb_set_lane_arbiter

Shares one colour-set assembly resource between two ball conveyor lanes. The resource is a collector that gathers one Green, one Blue and one Red ball, in any order and without overlap, into a complete set. A lane is granted by round-robin and keeps the lock until its set completes or a timeout expires. The block sits between the two lane feeders (valid/ready) and the downstream set-packing logic (done/abort pulses, set counter).

## Interface
Parameters:
- CNT_W, 8: width of the completed-set counter.
- TIMEOUT, 15: idle cycles in COLLECT (no handshake) before the lock is aborted; legal range 1..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_valid  input  1  lane 0 has a ball.
- in0_ball  input  2  lane 0 colour: 2'b00 Green, 2'b01 Blue, 2'b10 Red, 2'b11 invalid.
- in0_ready  output  1  lane 0 ball accepted this cycle when in0_valid is also high.
- in1_valid, in1_ball, in1_ready: same as lane 0, for lane 1.
- grant  output  2  one-hot owner lane; 2'b00 when idle.
- busy  output  1  high while in COLLECT.
- set_done  output  1  one-cycle pulse: a set is complete.
- abort  output  1  one-cycle pulse: lock released by timeout.
- set_lane  output  1  lane of the set_done/abort event; valid only with those pulses.
- reject  output  1  one-cycle pulse: the accepted ball was discarded (duplicate colour or code 2'b11).
- set_count  output  CNT_W  completed sets since reset; saturates at all-ones.

## Operation
- State is IDLE or COLLECT. Registers: owner, last_lane, mask[2:0] (bit0 G, bit1 B, bit2 R), and an idle counter.
- IDLE: inX_ready low. If exactly one lane is valid, grant it. If both are valid, grant the lane != last_lane. Next state is COLLECT with owner latched, mask cleared and the idle counter cleared. With no valid lane, stay in IDLE.
- COLLECT: in{owner}_ready = 1; the other lane's ready = 0. Ready is decoded from registered state only, with no valid-to-ready combinational path.
- On a handshake (valid & ready):
  - Ball 2'b11: reject pulse; mask unchanged.
  - Colour already set in mask: reject pulse; mask unchanged.
  - Otherwise: set the mask bit. If the mask becomes 3'b111:
    - set_done pulse with set_lane = owner;
    - set_count increments, saturating at all-ones;
    - last_lane = owner;
    - state goes to IDLE with mask cleared.
  - Any handshake clears the idle counter.
- Without a handshake the idle counter increments. When it reaches TIMEOUT:
  - abort pulse with set_lane = owner;
  - mask cleared; last_lane = owner;
  - state goes to IDLE. Partially collected balls are discarded.
- Non-overlap: the ball completing a set is never reused toward the next set.

## Timing
- Reset values: state IDLE, grant 0, busy 0, set_done 0, abort 0, reject 0, set_lane 0, set_count 0, mask 0, idle counter 0, last_lane 1 (so lane 0 wins the first tie).
- rst mid-COLLECT: the partial set is dropped and no abort pulse is issued.
- Grant latency: valid seen in IDLE at cycle t gives grant/busy/ready at t+1. The earliest handshake is t+1.
- set_done, abort, reject and set_lane are registered: each is asserted the cycle after its causing handshake or timeout event.
- set_count updates in the same cycle set_done is high.
- Completing handshake at cycle c: IDLE at c+1 (ready low), new grant at c+2. This gives a minimum of 1 dead cycle between sets.
- Timeout: with the last handshake (or grant) at cycle g, abort is high at g+TIMEOUT+1 and the state is IDLE in that same cycle.
- If the owner lane drops valid mid-set, the lock is held until timeout. The other lane is never served during a lock.
- A reject and a completion cannot coincide, since one ball is handled per cycle.

## Test plan
- Lane 0 only, balls R,G,B back-to-back after grant → set_done=1, set_lane=0 one cycle after the B handshake; set_count=1; grant=00 next cycle.
- Both lanes continuously valid after reset → grant order 01,10,01. Each set_done carries set_lane 0,1,0; set_count=3.
- Lane 1 sends G,G,3,B,R → reject pulses after the 2nd G and after code 3. set_done follows R; exactly 3 balls counted toward the set.
- Lane 0 sends G then drops valid, TIMEOUT=15 → abort=1, set_lane=0 exactly 16 cycles after the G handshake. Lane 1, valid throughout, is granted next cycle; set_count unchanged.
- rst asserted after 2 balls collected → all outputs at reset values next cycle; a fresh G,B,R after release yields set_done with set_count=1.
- Force set_count to all-ones (CNT_W=2, 4 sets) → value stays 2'b11 after the 4th set_done.

Source files
------------

// File: rtl/rgb_set_lane_arbiter_if.sv
// Lane/collector bundle for rgb_set_lane_arbiter: two lane feeders (valid/ball/ready) plus the downstream event outputs.
// Latency: none (signal bundle only).
// Backpressure: inX_ready is driven by the arbiter; feeders hold inX_valid/inX_ball until a ready cycle.
// Ports: master = lane feeders + downstream sink (test environment), slave = arbiter.
interface rgb_set_lane_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             in0_valid;
    logic [1:0]       in0_ball;
    logic             in0_ready;
    logic             in1_valid;
    logic [1:0]       in1_ball;
    logic             in1_ready;
    logic [1:0]       grant;
    logic             busy;
    logic             set_done;
    logic             abort;
    logic             set_lane;
    logic             reject;
    logic [CNT_W-1:0] set_count;

    modport master (
        output in0_valid, in0_ball, in1_valid, in1_ball,
        input  in0_ready, in1_ready, grant, busy, set_done, abort,
               set_lane, reject, set_count
    );

    modport slave (
        input  in0_valid, in0_ball, in1_valid, in1_ball,
        output in0_ready, in1_ready, grant, busy, set_done, abort,
               set_lane, reject, set_count
    );
endinterface

// File: rtl/rgb_set_lane_arbiter.sv
// Round-robin lock of one G/B/R set collector between two ball lanes; lock held until set complete or idle timeout.
// Latency: grant 1 cycle after valid in IDLE; set_done/abort/reject registered, 1 cycle after the causing event.
// Backpressure: only the owner lane sees ready during COLLECT; ready comes from registered state, never from valid.
// Ports: clk, rst (sync, active-high); lane_bus (slave) carries both lane handshakes, grant/busy,
//        set_done/abort/reject pulses, set_lane and the saturating set_count.
module rgb_set_lane_arbiter #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    rgb_set_lane_arbiter_if.slave lane_bus
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Idle counter fires one count before TIMEOUT so that abort lands
    // TIMEOUT+1 cycles after the last handshake once the pulse is registered.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    logic             r_owner;
    logic             r_last_lane;
    logic [2:0]       r_mask;
    logic [7:0]       r_idle_cnt;
    logic [1:0]       r_grant;
    logic             r_set_done;
    logic             r_abort;
    logic             r_reject;
    logic             r_set_lane;
    logic [CNT_W-1:0] r_set_count;

    logic             w_vld;
    logic [1:0]       w_ball;
    logic             w_hs;
    logic [2:0]       w_colour_bit;
    logic             w_invalid;
    logic             w_dup;
    logic [2:0]       w_mask_nxt;
    logic             w_complete;
    logic             w_timeout;
    logic             w_pick;

    always_comb begin
        w_vld        = r_owner ? lane_bus.in1_valid : lane_bus.in0_valid;
        w_ball       = r_owner ? lane_bus.in1_ball  : lane_bus.in0_ball;
        w_hs         = (r_state == ST_COLLECT) && w_vld;
        w_colour_bit = 3'b000;
        case (w_ball)
            2'b00:   w_colour_bit = 3'b001;
            2'b01:   w_colour_bit = 3'b010;
            2'b10:   w_colour_bit = 3'b100;
            default: w_colour_bit = 3'b000;
        endcase
        w_invalid  = (w_ball == 2'b11);
        w_dup      = |(w_colour_bit & r_mask);
        w_mask_nxt = r_mask | w_colour_bit;
        w_complete = w_hs && !w_invalid && !w_dup && (w_mask_nxt == 3'b111);
        w_timeout  = (r_state == ST_COLLECT) && !w_hs && (r_idle_cnt == TO_LAST);
        // Tie goes to the lane that did not own the previous lock.
        if (lane_bus.in0_valid && lane_bus.in1_valid) begin
            w_pick = ~r_last_lane;
        end else begin
            w_pick = lane_bus.in1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_last_lane <= 1'b1;
            r_mask      <= 3'b000;
            r_idle_cnt  <= 8'd0;
            r_grant     <= 2'b00;
            r_set_done  <= 1'b0;
            r_abort     <= 1'b0;
            r_reject    <= 1'b0;
            r_set_lane  <= 1'b0;
            r_set_count <= '0;
        end else begin
            r_set_done <= 1'b0;
            r_abort    <= 1'b0;
            r_reject   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (lane_bus.in0_valid || lane_bus.in1_valid) begin
                        r_state    <= ST_COLLECT;
                        r_owner    <= w_pick;
                        r_grant    <= w_pick ? 2'b10 : 2'b01;
                        r_mask     <= 3'b000;
                        r_idle_cnt <= 8'd0;
                    end
                end
                ST_COLLECT: begin
                    if (w_hs) begin
                        r_idle_cnt <= 8'd0;
                        if (w_invalid || w_dup) begin
                            r_reject <= 1'b1;
                        end else if (w_complete) begin
                            r_set_done  <= 1'b1;
                            r_set_lane  <= r_owner;
                            r_last_lane <= r_owner;
                            if (r_set_count != '1) begin
                                r_set_count <= r_set_count + 1'b1;
                            end
                            r_mask  <= 3'b000;
                            r_state <= ST_IDLE;
                            r_grant <= 2'b00;
                        end else begin
                            r_mask <= w_mask_nxt;
                        end
                    end else if (w_timeout) begin
                        // Partial set is dropped; the lock passes on like a completion.
                        r_abort     <= 1'b1;
                        r_set_lane  <= r_owner;
                        r_last_lane <= r_owner;
                        r_mask      <= 3'b000;
                        r_idle_cnt  <= 8'd0;
                        r_state     <= ST_IDLE;
                        r_grant     <= 2'b00;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign lane_bus.in0_ready = r_grant[0];
    assign lane_bus.in1_ready = r_grant[1];
    assign lane_bus.grant     = r_grant;
    assign lane_bus.busy      = (r_state == ST_COLLECT);
    assign lane_bus.set_done  = r_set_done;
    assign lane_bus.abort     = r_abort;
    assign lane_bus.reject    = r_reject;
    assign lane_bus.set_lane  = r_set_lane;
    assign lane_bus.set_count = r_set_count;

endmodule

// File: tb/tb_rgb_set_lane_arbiter.sv
// Directed bench for rgb_set_lane_arbiter: per-cycle vector table plus hand-written timeout and saturation sequences.
// Latency: each table row's expectations describe the outputs just after the clock edge that consumed its inputs.
// Backpressure: lanes hold valid as the vectors dictate; ready is checked against the expected grant.
module tb_rgb_set_lane_arbiter;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic clk;
    logic rst;

    rgb_set_lane_arbiter_if #(.CNT_W(8)) bus ();
    rgb_set_lane_arbiter_if #(.CNT_W(2)) bus2 ();

    rgb_set_lane_arbiter #(.CNT_W(8), .TIMEOUT(15)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .lane_bus (bus)
    );

    rgb_set_lane_arbiter #(.CNT_W(2), .TIMEOUT(15)) u_dut_sat (
        .clk      (clk),
        .rst      (rst),
        .lane_bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v0;
        logic [1:0] b0;
        logic       v1;
        logic [1:0] b1;
        logic [1:0] eg;
        logic       eb;
        logic       ed;
        logic       ea;
        logic       ej;
        logic       el;
        logic [7:0] ec;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs[NV];

    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(logic r, logic v0, logic [1:0] b0, logic v1, logic [1:0] b1,
                                logic [1:0] eg, logic eb, logic ed, logic ea, logic ej,
                                logic el, logic [7:0] ec);
        vec_t v;
        v.r = r; v.v0 = v0; v.b0 = b0; v.v1 = v1; v.b1 = b1;
        v.eg = eg; v.eb = eb; v.ed = ed; v.ea = ea; v.ej = ej; v.el = el; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Lane 0 R,G,B
        vecs[0]  = mk(1, 0, G, 0, G, 2'b00, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, R, 0, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, R, 0, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, G, 0, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, B, 0, G, 2'b00, 0, 1, 0, 0, 0, 1);
        vecs[5]  = mk(0, 0, G, 0, G, 2'b00, 0, 0, 0, 0, 0, 1);
        // Both lanes continuously valid after reset: 01,10,01
        vecs[6]  = mk(1, 0, G, 0, G, 2'b00, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, G, 1, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 1, G, 1, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, B, 1, B, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, R, 1, R, 2'b00, 0, 1, 0, 0, 0, 1);
        vecs[11] = mk(0, 1, G, 1, G, 2'b10, 1, 0, 0, 0, 0, 1);
        vecs[12] = mk(0, 1, G, 1, G, 2'b10, 1, 0, 0, 0, 0, 1);
        vecs[13] = mk(0, 1, B, 1, B, 2'b10, 1, 0, 0, 0, 0, 1);
        vecs[14] = mk(0, 1, R, 1, R, 2'b00, 0, 1, 0, 0, 1, 2);
        vecs[15] = mk(0, 1, G, 1, G, 2'b01, 1, 0, 0, 0, 0, 2);
        vecs[16] = mk(0, 1, G, 1, G, 2'b01, 1, 0, 0, 0, 0, 2);
        vecs[17] = mk(0, 1, B, 1, B, 2'b01, 1, 0, 0, 0, 0, 2);
        vecs[18] = mk(0, 1, R, 1, R, 2'b00, 0, 1, 0, 0, 0, 3);
        vecs[19] = mk(0, 0, G, 0, G, 2'b00, 0, 0, 0, 0, 0, 3);
        // Lane 1: G,G,3,B,R with rejects
        vecs[20] = mk(0, 0, G, 1, G, 2'b10, 1, 0, 0, 0, 0, 3);
        vecs[21] = mk(0, 0, G, 1, G, 2'b10, 1, 0, 0, 0, 0, 3);
        vecs[22] = mk(0, 0, G, 1, G, 2'b10, 1, 0, 0, 1, 0, 3);
        vecs[23] = mk(0, 0, G, 1, X, 2'b10, 1, 0, 0, 1, 0, 3);
        vecs[24] = mk(0, 0, G, 1, B, 2'b10, 1, 0, 0, 0, 0, 3);
        vecs[25] = mk(0, 0, G, 1, R, 2'b00, 0, 1, 0, 0, 1, 4);
        vecs[26] = mk(0, 0, G, 0, G, 2'b00, 0, 0, 0, 0, 0, 4);
        // Reset after two balls, then a fresh set
        vecs[27] = mk(0, 1, G, 0, G, 2'b01, 1, 0, 0, 0, 0, 4);
        vecs[28] = mk(0, 1, G, 0, G, 2'b01, 1, 0, 0, 0, 0, 4);
        vecs[29] = mk(0, 1, B, 0, G, 2'b01, 1, 0, 0, 0, 0, 4);
        vecs[30] = mk(1, 1, R, 0, G, 2'b00, 0, 0, 0, 0, 0, 0);
        vecs[31] = mk(0, 1, G, 0, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[32] = mk(0, 1, G, 0, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[33] = mk(0, 1, B, 0, G, 2'b01, 1, 0, 0, 0, 0, 0);
        vecs[34] = mk(0, 1, R, 0, G, 2'b00, 0, 1, 0, 0, 0, 1);

        rst = 1'b1;
        bus.in0_valid = 1'b0; bus.in0_ball = G;
        bus.in1_valid = 1'b0; bus.in1_ball = G;
        bus2.in0_valid = 1'b0; bus2.in0_ball = G;
        bus2.in1_valid = 1'b0; bus2.in1_ball = G;

        for (int i = 0; i < NV; i++) begin
            rst           = vecs[i].r;
            bus.in0_valid = vecs[i].v0;
            bus.in0_ball  = vecs[i].b0;
            bus.in1_valid = vecs[i].v1;
            bus.in1_ball  = vecs[i].b1;
            step();
            chk($sformatf("row%0d grant", i),    {6'd0, bus.grant},     {6'd0, vecs[i].eg});
            chk($sformatf("row%0d ready0", i),   {7'd0, bus.in0_ready}, {7'd0, vecs[i].eg[0]});
            chk($sformatf("row%0d ready1", i),   {7'd0, bus.in1_ready}, {7'd0, vecs[i].eg[1]});
            chk($sformatf("row%0d busy", i),     {7'd0, bus.busy},      {7'd0, vecs[i].eb});
            chk($sformatf("row%0d set_done", i), {7'd0, bus.set_done},  {7'd0, vecs[i].ed});
            chk($sformatf("row%0d abort", i),    {7'd0, bus.abort},     {7'd0, vecs[i].ea});
            chk($sformatf("row%0d reject", i),   {7'd0, bus.reject},    {7'd0, vecs[i].ej});
            chk($sformatf("row%0d set_count", i), bus.set_count,        vecs[i].ec);
            if (vecs[i].ed || vecs[i].ea || vecs[i].r) begin
                chk($sformatf("row%0d set_lane", i), {7'd0, bus.set_lane}, {7'd0, vecs[i].el});
            end
        end

        // Timeout: lane 0 sends one G then drops valid; lane 1 waits throughout.
        rst = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_ball = G;
        bus.in1_valid = 1'b0; bus.in1_ball = G;
        step();
        chk("to grant0", {6'd0, bus.grant}, 8'h01);
        bus.in1_valid = 1'b1;
        step();   // G handshake on lane 0
        chk("to after G busy", {7'd0, bus.busy}, 8'h01);
        bus.in0_valid = 1'b0;
        for (int k = 1; k < 15; k++) begin
            step();
            chk($sformatf("to wait%0d abort", k),  {7'd0, bus.abort},     8'h00);
            chk($sformatf("to wait%0d ready1", k), {7'd0, bus.in1_ready}, 8'h00);
            chk($sformatf("to wait%0d grant", k),  {6'd0, bus.grant},     8'h01);
        end
        step();   // 16th cycle after the G handshake
        chk("to abort",     {7'd0, bus.abort},    8'h01);
        chk("to set_lane",  {7'd0, bus.set_lane}, 8'h00);
        chk("to grant idle", {6'd0, bus.grant},   8'h00);
        chk("to busy idle", {7'd0, bus.busy},     8'h00);
        chk("to set_done",  {7'd0, bus.set_done}, 8'h00);
        chk("to set_count", bus.set_count,        8'd1);
        step();
        chk("to lane1 grant", {6'd0, bus.grant}, 8'h02);
        chk("to abort clear", {7'd0, bus.abort}, 8'h00);
        bus.in1_valid = 1'b0;

        // Saturation on the 2-bit counter instance.
        for (int s = 1; s <= 5; s++) begin
            bus2.in0_valid = 1'b1;
            bus2.in0_ball = G; step();
            chk($sformatf("sat%0d grant", s), {6'd0, bus2.grant}, 8'h01);
            bus2.in0_ball = G; step();
            bus2.in0_ball = B; step();
            bus2.in0_ball = R; step();
            chk($sformatf("sat%0d set_done", s), {7'd0, bus2.set_done}, 8'h01);
            chk($sformatf("sat%0d set_count", s), {6'd0, bus2.set_count},
                (s > 3) ? 8'd3 : 8'(s));
        end
        bus2.in0_valid = 1'b0;
        step();
        chk("sat hold", {6'd0, bus2.set_count}, 8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
